mod_148_4_6_plca_status: RTL and testbench

// Clocked PLCA status state machine (148.4.6) for the P802.3da node.

---
 rtl/pkg_148_plca.sv | 18 +
 rtl/mod_148_4_6_plca_status_if.sv | 23 ++
 rtl/mod_148_4_6_status_timer_sync.sv | 46 ++++
 rtl/mod_148_4_6_plca_status.sv | 95 +++++++++
 tb/tb_mod_148_4_6_plca_status.sv | 229 ++++++++++++++++++++++
 5 files changed

// File: rtl/pkg_148_plca.sv
// Shared clause-148 PLCA definitions: status state encoding and PLCA_STATUS values.
package pkg_148_plca;

  typedef enum logic [1:0] {
    PLCA_STATUS_DISABLED   = 2'd0,
    PLCA_STATUS_INACTIVE   = 2'd1,
    PLCA_STATUS_ACTIVE     = 2'd2,
    PLCA_STATUS_HYSTERESIS = 2'd3
  } plca_status_state_t;

  localparam logic STATUS_OK   = 1'b1;
  localparam logic STATUS_FAIL = 1'b0;

  function automatic logic status_of(plca_status_state_t s);
    return ((s == PLCA_STATUS_ACTIVE) || (s == PLCA_STATUS_HYSTERESIS)) ? STATUS_OK : STATUS_FAIL;
  endfunction

endpackage

// File: rtl/mod_148_4_6_plca_status_if.sv
// Control/status bundle between the PLCA data path, management and the status FSM.
interface mod_148_4_6_plca_status_if;

  logic       plca_en;
  logic       plca_reset;
  logic       rx_beacon;
  logic       tx_beacon;
  logic       plca_status;
  logic [1:0] plca_status_state;
  logic       plca_status_timer_done;
  logic       plca_status_timer_not_done;

  modport slave (
    input  plca_en, plca_reset, rx_beacon, tx_beacon,
    output plca_status, plca_status_state, plca_status_timer_done, plca_status_timer_not_done
  );

  modport master (
    output plca_en, plca_reset, rx_beacon, tx_beacon,
    input  plca_status, plca_status_state, plca_status_timer_done, plca_status_timer_not_done
  );

endinterface

// File: rtl/mod_148_4_6_status_timer_sync.sv
// Generic clause-148 timer: start/restart and stop, registered done/not_done, saturating count.
module mod_148_4_6_status_timer_sync #(
  parameter int TICKS = 326,
  parameter int W     = 16
) (
  input  logic clk,
  input  logic reset_n,
  input  logic i_start,
  input  logic i_stop,
  output logic o_done,
  output logic o_not_done
);

  localparam logic [W-1:0] LP_LAST      = W'(TICKS - 1);
  localparam logic [W-1:0] LP_FULL      = W'(TICKS);
  localparam logic         LP_IMMEDIATE = (TICKS <= 1);

  logic [W-1:0] r_cnt;
  logic         r_done;
  logic         r_not_done;

  // r_cnt holds cycles elapsed since the start edge, so the start edge itself counts as one.
  always_ff @(posedge clk) begin
    if (!reset_n || i_stop) begin
      r_cnt      <= '0;
      r_done     <= 1'b0;
      r_not_done <= 1'b0;
    end else if (i_start) begin
      r_cnt      <= LP_IMMEDIATE ? LP_FULL : W'(1);
      r_done     <= LP_IMMEDIATE;
      r_not_done <= !LP_IMMEDIATE;
    end else if (r_not_done) begin
      if (r_cnt >= LP_LAST) begin
        r_cnt      <= LP_FULL;
        r_done     <= 1'b1;
        r_not_done <= 1'b0;
      end else begin
        r_cnt <= r_cnt + W'(1);
      end
    end
  end

  assign o_done     = r_done;
  assign o_not_done = r_not_done;

endmodule

// File: rtl/mod_148_4_6_plca_status.sv
// PLCA status FSM: tracks BEACON activity and reports PLCA_STATUS OK/FAIL with hysteresis.
//   state      | meaning
//   DISABLED   | PLCA off or held in reset, status FAIL
//   INACTIVE   | enabled, no recent BEACON, status FAIL
//   ACTIVE     | BEACONs arriving, status OK, timer watches for the next one
//   HYSTERESIS | one timer period missed, status still OK, second chance
module mod_148_4_6_plca_status
  import pkg_148_plca::*;
#(
  parameter int STATUS_TIMER_TICKS = 326,
  parameter int TIMER_W            = 16
) (
  input logic                          clk,
  input logic                          reset_n,
  mod_148_4_6_plca_status_if.slave     plca_if
);

  plca_status_state_t r_state;
  plca_status_state_t w_next_state;
  logic               r_status;
  logic               w_beacon;
  logic               w_disable;
  logic               w_start;
  logic               w_stop;
  logic               w_timer_done;
  logic               w_timer_not_done;

  assign w_beacon  = plca_if.rx_beacon | plca_if.tx_beacon;
  assign w_disable = !plca_if.plca_en | plca_if.plca_reset;

  always_comb begin
    w_next_state = r_state;
    w_start      = 1'b0;
    if (w_disable) begin
      w_next_state = PLCA_STATUS_DISABLED;
    end else begin
      case (r_state)
        PLCA_STATUS_DISABLED: w_next_state = PLCA_STATUS_INACTIVE;
        PLCA_STATUS_INACTIVE: begin
          if (w_beacon) begin
            w_next_state = PLCA_STATUS_ACTIVE;
            w_start      = 1'b1;
          end
        end
        PLCA_STATUS_ACTIVE: begin
          if (w_beacon) begin
            w_start = 1'b1;
          end else if (w_timer_done) begin
            w_next_state = PLCA_STATUS_HYSTERESIS;
            w_start      = 1'b1;
          end
        end
        PLCA_STATUS_HYSTERESIS: begin
          // A beacon coinciding with expiry still counts as activity.
          if (w_beacon) begin
            w_next_state = PLCA_STATUS_ACTIVE;
            w_start      = 1'b1;
          end else if (w_timer_done) begin
            w_next_state = PLCA_STATUS_INACTIVE;
          end
        end
        default: w_next_state = PLCA_STATUS_DISABLED;
      endcase
    end
    w_stop = (w_next_state == PLCA_STATUS_DISABLED) || (w_next_state == PLCA_STATUS_INACTIVE);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state  <= PLCA_STATUS_DISABLED;
      r_status <= STATUS_FAIL;
    end else begin
      r_state  <= w_next_state;
      r_status <= status_of(w_next_state);
    end
  end

  mod_148_4_6_status_timer_sync #(
    .TICKS (STATUS_TIMER_TICKS),
    .W     (TIMER_W)
  ) u_status_timer (
    .clk        (clk),
    .reset_n    (reset_n),
    .i_start    (w_start),
    .i_stop     (w_stop),
    .o_done     (w_timer_done),
    .o_not_done (w_timer_not_done)
  );

  assign plca_if.plca_status                = r_status;
  assign plca_if.plca_status_state          = r_state;
  assign plca_if.plca_status_timer_done     = w_timer_done;
  assign plca_if.plca_status_timer_not_done = w_timer_not_done;

endmodule

// File: tb/tb_mod_148_4_6_plca_status.sv
// Self-checking bench for the PLCA status FSM: vector table, directed corner cases, random run.
module tb_mod_148_4_6_plca_status;

  localparam int TICKS = 10;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  mod_148_4_6_plca_status_if u_if ();

  mod_148_4_6_plca_status #(
    .STATUS_TIMER_TICKS (TICKS),
    .TIMER_W            (16)
  ) u_dut (
    .clk     (clk),
    .reset_n (reset_n),
    .plca_if (u_if.slave)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Reference: state as plain number, timer as "cycle it was started in".
  int m_state = 0;
  bit m_run   = 1'b0;
  int m_start = 0;

  function automatic bit m_done(int c);
    return m_run && ((c - m_start) >= TICKS);
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step();
    bit b;
    bit d;
    b = u_if.rx_beacon | u_if.tx_beacon;
    d = m_done(cyc);
    if (!reset_n || !u_if.plca_en || u_if.plca_reset) begin
      m_state = 0;
      m_run   = 1'b0;
    end else begin
      case (m_state)
        0: m_state = 1;
        1: if (b) begin m_state = 2; m_run = 1'b1; m_start = cyc; end
        2: begin
          if (b) m_start = cyc;
          else if (d) begin m_state = 3; m_start = cyc; end
        end
        default: begin
          if (b) begin m_state = 2; m_start = cyc; end
          else if (d) begin m_state = 1; m_run = 1'b0; end
        end
      endcase
    end
    @(posedge clk);
    cyc++;
    #1;
    chk("model_state", int'(u_if.plca_status_state), m_state);
    chk("model_status", int'(u_if.plca_status), int'(m_state >= 2));
    chk("model_done", int'(u_if.plca_status_timer_done), int'(m_done(cyc)));
    chk("model_not_done", int'(u_if.plca_status_timer_not_done), int'(m_run && !m_done(cyc)));
  endtask

  task automatic chk_all(input string name, input int st, input int status, input int done, input int nd);
    chk({name, "_state"}, int'(u_if.plca_status_state), st);
    chk({name, "_status"}, int'(u_if.plca_status), status);
    chk({name, "_done"}, int'(u_if.plca_status_timer_done), done);
    chk({name, "_not_done"}, int'(u_if.plca_status_timer_not_done), nd);
  endtask

  typedef struct {
    bit en;
    bit rs;
    bit rx;
    bit tx;
    int st;
    int status;
    int done;
    int nd;
  } vec_t;

  vec_t vecs[10];

  initial begin
    int first;
    int seen;
    int drops;

    vecs[0] = '{1, 0, 0, 0, 1, 0, 0, 0};
    vecs[1] = '{1, 0, 1, 0, 2, 1, 0, 1};
    vecs[2] = '{1, 0, 0, 0, 2, 1, 0, 1};
    vecs[3] = '{1, 0, 0, 1, 2, 1, 0, 1};
    vecs[4] = '{0, 0, 1, 0, 0, 0, 0, 0};
    vecs[5] = '{1, 0, 1, 0, 1, 0, 0, 0};
    vecs[6] = '{1, 1, 0, 0, 0, 0, 0, 0};
    vecs[7] = '{1, 0, 0, 0, 1, 0, 0, 0};
    vecs[8] = '{1, 0, 0, 1, 2, 1, 0, 1};
    vecs[9] = '{1, 1, 1, 0, 0, 0, 0, 0};

    reset_n          = 1'b0;
    u_if.plca_en     = 1'b1;
    u_if.plca_reset  = 1'b0;
    u_if.rx_beacon   = 1'b0;
    u_if.tx_beacon   = 1'b0;

    // reset then release
    repeat (3) step();
    chk_all("reset", 0, 0, 0, 0);
    reset_n = 1'b1;
    step();
    chk("release_state", int'(u_if.plca_status_state), 1);
    chk("release_status", int'(u_if.plca_status), 0);

    for (int i = 0; i < 10; i++) begin
      u_if.plca_en    = vecs[i].en;
      u_if.plca_reset = vecs[i].rs;
      u_if.rx_beacon  = vecs[i].rx;
      u_if.tx_beacon  = vecs[i].tx;
      step();
      chk_all($sformatf("vec%0d", i), vecs[i].st, vecs[i].status, vecs[i].done, vecs[i].nd);
    end
    u_if.plca_en    = 1'b1;
    u_if.plca_reset = 1'b0;
    u_if.rx_beacon  = 1'b0;
    u_if.tx_beacon  = 1'b0;
    step();

    // beacon -> ACTIVE, done exactly TICKS cycles after the beacon cycle
    u_if.rx_beacon = 1'b1;
    step();
    u_if.rx_beacon = 1'b0;
    chk_all("t2_entry", 2, 1, 0, 1);
    first = -1;
    for (int k = 2; k <= 20 && first < 0; k++) begin
      step();
      if (u_if.plca_status_timer_done) first = k;
    end
    chk("t2_done_cycle", first, TICKS);

    // no beacon -> HYSTERESIS next cycle, INACTIVE one period later
    step();
    chk("t4_hyst_state", int'(u_if.plca_status_state), 3);
    chk("t4_hyst_status", int'(u_if.plca_status), 1);
    first = -1;
    for (int k = 1; k <= 20 && first < 0; k++) begin
      step();
      if (u_if.plca_status_state == 2'd1) first = k;
    end
    chk("t4_inactive_delay", first, TICKS);
    chk("t4_inactive_status", int'(u_if.plca_status), 0);

    // beacons every 8 cycles keep the timer from expiring
    u_if.rx_beacon = 1'b1;
    step();
    u_if.rx_beacon = 1'b0;
    seen  = 0;
    drops = 0;
    for (int i = 0; i < 50; i++) begin
      u_if.tx_beacon = ((i % 8) == 7);
      step();
      if (u_if.plca_status_timer_done) seen++;
      if (!u_if.plca_status) drops++;
    end
    u_if.tx_beacon = 1'b0;
    chk("t3_done_seen", seen, 0);
    chk("t3_status_drops", drops, 0);

    // beacon coincident with expiry in HYSTERESIS
    first = -1;
    for (int k = 0; k < 30 && first < 0; k++) begin
      step();
      if (u_if.plca_status_state == 2'd3) first = k;
    end
    chk("t5_reached_hyst", int'(first >= 0), 1);
    first = -1;
    for (int k = 0; k < 20 && first < 0; k++) begin
      if (u_if.plca_status_timer_done) first = k;
      else step();
    end
    chk("t5_done_in_hyst", int'(u_if.plca_status_state), 3);
    u_if.tx_beacon = 1'b1;
    step();
    u_if.tx_beacon = 1'b0;
    chk_all("t5_coincident", 2, 1, 0, 1);

    // plca_reset with beacon mid-count, then reset_n mid-count
    repeat (3) step();
    u_if.plca_reset = 1'b1;
    u_if.rx_beacon  = 1'b1;
    step();
    u_if.plca_reset = 1'b0;
    u_if.rx_beacon  = 1'b0;
    chk_all("t6_plca_reset", 0, 0, 0, 0);
    step();
    u_if.rx_beacon = 1'b1;
    step();
    u_if.rx_beacon = 1'b0;
    repeat (4) step();
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    chk_all("t6_reset_n", 0, 0, 0, 0);
    step();
    chk("t6_no_residual_done", int'(u_if.plca_status_timer_done), 0);

    // random traffic against the reference
    for (int i = 0; i < 3000; i++) begin
      u_if.plca_en    = ($urandom % 50) != 0;
      u_if.plca_reset = ($urandom % 80) == 0;
      u_if.rx_beacon  = ($urandom % 12) == 0;
      u_if.tx_beacon  = ($urandom % 20) == 0;
      reset_n         = ($urandom % 200) != 0;
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
